// File: rtl/lcd_sensor_feeder.sv
// lcd_sensor_feeder: per-channel sample averaging and periodic publish for the LCD1602 controller, plus power-up ready.
// Define LCD_SENSOR_AVG_EN for block averaging; otherwise each publish carries the latest sample.
module lcd_sensor_feeder #(
  parameter int DATA_BITS      = 8,
  parameter int AVG_LOG2       = 2,
  parameter int POWERUP_CYCLES = 2500000,
  parameter int REFRESH_CYCLES = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           s_valid,
  input  logic [DATA_BITS-1:0] s_data_0,
  input  logic [DATA_BITS-1:0] s_data_1,
  input  logic [DATA_BITS-1:0] s_data_2,
  output logic [DATA_BITS-1:0] data_1_sen,
  output logic [DATA_BITS-1:0] data_2_sen,
  output logic [DATA_BITS-1:0] data_3_sen,
  output logic                 ready_o,
  output logic                 update_o,
  output logic [2:0]           stale_o
);
  localparam int CW = $clog2(POWERUP_CYCLES > REFRESH_CYCLES ? POWERUP_CYCLES : REFRESH_CYCLES);
  typedef enum logic [1:0] {POWERUP, COLLECT, PUBLISH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pub, ready_q, ready_d, update_q;
  logic [2:0] accept, done, fresh_q, fresh_d, stale_q, stale_d;
  logic [2:0][DATA_BITS-1:0] smp, pend_q, pend_d, out_q, out_d;
`ifdef LCD_SENSOR_AVG_EN
  localparam int AW = DATA_BITS + AVG_LOG2;
  logic [2:0][AW-1:0] acc_q, acc_d, sum;
  logic [2:0][AVG_LOG2-1:0] scnt_q, scnt_d;
`endif
  assign smp = {s_data_2, s_data_1, s_data_0};
  assign accept = s_valid & {3{state_q != POWERUP}};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    pub = 1'b0;
    case (state_q)
      POWERUP: if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
        state_d = COLLECT;
        cnt_d = '0;
      end
      COLLECT: if (cnt_q == CW'(REFRESH_CYCLES - 1)) begin
        state_d = PUBLISH;
        cnt_d = '0;
        pub = 1'b1;
      end
      default: begin
        state_d = COLLECT;
        cnt_d = '0;
      end
    endcase
  end
  assign ready_d = ready_q | (state_q == POWERUP && cnt_q == CW'(POWERUP_CYCLES - 1));
  always_comb begin
    done = '0;
    pend_d = pend_q;
`ifdef LCD_SENSOR_AVG_EN
    sum = '0;
    acc_d = acc_q;
    scnt_d = scnt_q;
`endif
    for (int k = 0; k < 3; k++) begin
`ifdef LCD_SENSOR_AVG_EN
      sum[k] = acc_q[k] + AW'(smp[k]);
      done[k] = accept[k] & (&scnt_q[k]);
      acc_d[k] = done[k] ? '0 : accept[k] ? sum[k] : acc_q[k];
      scnt_d[k] = scnt_q[k] + AVG_LOG2'(accept[k]);
      pend_d[k] = done[k] ? DATA_BITS'(sum[k] >> AVG_LOG2) : pend_q[k];
`else
      done[k] = accept[k];
      pend_d[k] = done[k] ? smp[k] : pend_q[k];
`endif
      out_d[k] = pub ? pend_q[k] : out_q[k];
    end
    // a block finishing on the publish edge stays fresh for the next publish
    fresh_d = done | (fresh_q & {3{~pub}});
    stale_d = pub ? ~fresh_q : stale_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= POWERUP;
      cnt_q <= '0;
      ready_q <= 1'b0;
      update_q <= 1'b0;
      fresh_q <= '0;
      stale_q <= '0;
      pend_q <= '0;
      out_q <= '0;
`ifdef LCD_SENSOR_AVG_EN
      acc_q <= '0;
      scnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      update_q <= pub;
      fresh_q <= fresh_d;
      stale_q <= stale_d;
      pend_q <= pend_d;
      out_q <= out_d;
`ifdef LCD_SENSOR_AVG_EN
      acc_q <= acc_d;
      scnt_q <= scnt_d;
`endif
    end
  end
  assign data_1_sen = out_q[0];
  assign data_2_sen = out_q[1];
  assign data_3_sen = out_q[2];
  assign ready_o = ready_q;
  assign update_o = update_q;
  assign stale_o = stale_q;
endmodule

// File: tb/tb_lcd_sensor_feeder.sv
// tb_lcd_sensor_feeder: random and directed stimulus checked against a cycle-count based reference model.
module tb_lcd_sensor_feeder;
  localparam int P = 10;
  localparam int R = 20;
  localparam int BLK = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] s_valid = '0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [7:0] data_1_sen, data_2_sen, data_3_sen;
  logic ready_o, update_o;
  logic [2:0] stale_o;
  int tests = 0, fails = 0;
  int n = 0;
  int m_acc[3], m_cnt[3];
  logic [7:0] m_pend[3], m_out[3];
  logic [2:0] m_fresh = '0, m_stale = '0;
  logic m_ready = 1'b0, m_upd = 1'b0;

  lcd_sensor_feeder #(.DATA_BITS(8), .AVG_LOG2(2), .POWERUP_CYCLES(P), .REFRESH_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid),
    .s_data_0(d0), .s_data_1(d1), .s_data_2(d2),
    .data_1_sen(data_1_sen), .data_2_sen(data_2_sen), .data_3_sen(data_3_sen),
    .ready_o(ready_o), .update_o(update_o), .stale_o(stale_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Publishes fall on fixed edge numbers counted from reset release.
  task automatic model_edge();
    logic [7:0] smp[3];
    smp = '{d0, d1, d2};
    if (!reset) begin
      n = 0; m_ready = 0; m_upd = 0; m_stale = '0; m_fresh = '0;
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_pend[k] = '0; m_out[k] = '0;
      end
    end else begin
      n++;
      m_ready = (n >= P);
      m_upd = (n >= P + R) && ((n - P - R) % (R + 1) == 0);
      if (m_upd) begin
        m_stale = ~m_fresh;
        for (int k = 0; k < 3; k++) m_out[k] = m_pend[k];
        m_fresh = '0;
      end
      if (n > P)
        for (int k = 0; k < 3; k++)
          if (s_valid[k]) begin
`ifdef LCD_SENSOR_AVG_EN
            m_acc[k] += int'(smp[k]);
            m_cnt[k]++;
            if (m_cnt[k] == BLK) begin
              m_pend[k] = 8'(m_acc[k] / BLK);
              m_acc[k] = 0;
              m_cnt[k] = 0;
              m_fresh[k] = 1'b1;
            end
`else
            m_pend[k] = smp[k];
            m_fresh[k] = 1'b1;
`endif
          end
    end
  endtask

  task automatic step(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    s_valid = v; d0 = a; d1 = b; d2 = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ready", ready_o, m_ready);
    check("update", update_o, m_upd);
    check("stale", stale_o, m_stale);
    check("data_1", data_1_sen, m_out[0]);
    check("data_2", data_2_sen, m_out[1]);
    check("data_3", data_3_sen, m_out[2]);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b0;
    for (int k = 0; k < cyc; k++) step(3'b000, 8'd0, 8'd0, 8'd0);
    reset = 1'b1;
  endtask

  task automatic run_to_pub();
    int k = 0;
    do begin
      step(3'b000, 8'd0, 8'd0, 8'd0);
      k++;
    end while (!update_o && k < 2 * R);
    if (!update_o) check("pub_wait", update_o, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);
    check("rst_ready", ready_o, 0);
    check("rst_stale", stale_o, 0);
    for (int k = 0; k < P; k++) step((k >= 2 && k < 6) ? 3'b001 : 3'b000, 8'd200, 8'd0, 8'd0);
    check("ready_up", ready_o, 1);
    step(3'b101, 8'd10, 8'd0, 8'd255);
    step(3'b101, 8'd20, 8'd0, 8'd255);
    step(3'b101, 8'd30, 8'd0, 8'd255);
    step(3'b101, 8'd41, 8'd0, 8'd255);
    run_to_pub();
`ifdef LCD_SENSOR_AVG_EN
    check("avg_ch0", data_1_sen, 25);
`else
    check("last_ch0", data_1_sen, 41);
`endif
    check("full_ch2", data_3_sen, 255);
    check("stale_010", stale_o, 3'b010);
    step(3'b000, 8'd0, 8'd0, 8'd0);
    check("upd_one", update_o, 0);
    do_reset(2);
    for (int k = 0; k < P; k++) step((k < 4) ? 3'b001 : 3'b000, 8'd200, 8'd0, 8'd0);
    for (int k = 0; k < 4; k++) step(3'b001, 8'd8, 8'd0, 8'd0);
    run_to_pub();
    check("mask_pwr", data_1_sen, 8);
    for (int k = 0; k < 4 * (R + 1); k++) begin
      logic [2:0] v;
      v = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      step(v, 8'($urandom), 8'($urandom_range(240, 255)), 8'($urandom));
    end
    step(3'b010, 8'd0, 8'd100, 8'd0);
    step(3'b010, 8'd0, 8'd100, 8'd0);
    step(3'b010, 8'd0, 8'd100, 8'd0);
    do_reset(2);
    for (int k = 0; k < P; k++) step(3'b000, 8'd0, 8'd0, 8'd0);
    step(3'b010, 8'd0, 8'd4, 8'd0);
    run_to_pub();
`ifdef LCD_SENSOR_AVG_EN
    check("rst_blk_d", data_2_sen, 0);
    check("rst_blk_s", stale_o[1], 1);
`else
    check("rst_blk_d", data_2_sen, 4);
    check("rst_blk_s", stale_o[1], 0);
`endif
    step(3'b001, 8'd7, 8'd0, 8'd0);
    step(3'b001, 8'd9, 8'd0, 8'd0);
    run_to_pub();
`ifndef LCD_SENSOR_AVG_EN
    check("latest_d", data_1_sen, 9);
    check("latest_s", stale_o[0], 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_sensor_feeder.md
# lcd_sensor_feeder

Upstream stage of the LCD1602 display controller. It collects raw 8-bit readings from three sensor channels and block-averages each channel. At a fixed refresh rate it publishes stable values on `data_1_sen`/`data_2_sen`/`data_3_sen`. It also generates the controller's `ready_i` once the LCD power-up delay has elapsed.

## Interface
Parameters:
- `DATA_BITS`, 8: sample and output width.
- `AVG_LOG2`, 2: log2 of the samples per averaging block (4 samples).
- `POWERUP_CYCLES`, 2500000: clk cycles before `ready_o` rises (50 ms at 50 MHz).
- `REFRESH_CYCLES`, 25000000: clk cycles between publishes (0.5 s).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `s_valid`  in  3  per-channel one-cycle sample strobe; bit i belongs to channel i.
- `s_data_0`, `s_data_1`, `s_data_2`  in  DATA_BITS each  raw samples, qualified by `s_valid[i]`.
- `data_1_sen`, `data_2_sen`, `data_3_sen`  out  DATA_BITS each  published values for channels 0/1/2.
- `ready_o`  out  1  drives the controller's `ready_i`; stays high once set.
- `update_o`  out  1  one-cycle pulse, concurrent with each publish.
- `stale_o`  out  3  bit i = 1 when channel i had no fresh value at the last publish.

## Operation
- FSM states:
  - POWERUP: power-up counter runs. Moves to COLLECT when the counter reaches POWERUP_CYCLES-1.
  - COLLECT: refresh counter runs. Moves to PUBLISH when the counter reaches REFRESH_CYCLES-1.
  - PUBLISH: lasts one cycle, then returns to COLLECT. The refresh counter restarts at 0.
- Samples are ignored in POWERUP. Sample acceptance is independent of the FSM in COLLECT and PUBLISH.
- Each channel holds:
  - an accumulator, DATA_BITS+AVG_LOG2 bits wide, so it never overflows;
  - a sample counter, AVG_LOG2 bits;
  - a `pending` register;
  - a `fresh` flag.
- On `s_valid[i]`: accumulator += sample and the counter increments.
- On the 2^AVG_LOG2-th sample: `pending` <= (acc + sample) >> AVG_LOG2, truncating. Accumulator and counter clear; `fresh` <= 1.
- PUBLISH, for each channel:
  - output <= `pending` as it was before this cycle;
  - `stale_o[i]` <= ~`fresh`;
  - `fresh` <= 0, unless a block completes in this same cycle. In that case the new `pending` is stored for the next publish and `fresh` stays 1.
- A stale channel keeps its previous output value.
- Channels are fully independent. Simultaneous strobes on all three channels are all accepted.

## Timing
- All outputs are registered.
- Reset values: all data outputs 0, `ready_o` 0, `update_o` 0, `stale_o` 3'b000. The FSM, all counters, accumulators, `pending` and `fresh` also clear.
- `ready_o` rises on the edge that ends cycle POWERUP_CYCLES after reset release.
- The first publish comes REFRESH_CYCLES cycles after `ready_o` rises. Publishes then repeat every REFRESH_CYCLES+1 cycles.
- Data outputs, `stale_o` and `update_o` change on the same edge.
- Sample-to-output latency: the block completes, then the value appears at the next publish.
- A reset asserted mid-block discards any partial accumulation and returns the FSM to POWERUP.

## Configuration
- `LCD_SENSOR_AVG_EN` defined: block averaging, as described above.
- Not defined:
  - no accumulators;
  - every `s_valid[i]` loads `pending` <= sample and sets `fresh`;
  - a publish outputs the latest sample;
  - `AVG_LOG2` is unused.

## Test plan
All scenarios use POWERUP_CYCLES=10, REFRESH_CYCLES=20, AVG_LOG2=2, macro defined unless noted.
- Power-up: hold reset low 3 cycles, then release. `ready_o`=0 for 10 cycles, then 1 permanently. All data outputs stay 0 until the first `update_o`.
- Averaging and stale: channel 0 gets 10, 20, 30, 41; channels 1 and 2 idle. At publish, `data_1_sen`=25, `stale_o`=3'b110, and `update_o` pulses once.
- Full scale: four samples of 255 on channel 2. Result `data_3_sen`=255 with no wrap.
- POWERUP masking: four strobes of 200 during POWERUP, then four of 8 during COLLECT. Published value is 8.
- Reset mid-block: three samples of 100 on channel 1, then reset, then power-up, then one sample of 4. At the first publish, `data_2_sen`=0 and `stale_o[1]`=1.
- Macro undefined: channel 0 gets 7 then 9 before a publish. `data_1_sen`=9 and `stale_o[0]`=0.
